id_pipe_stage: RTL and testbench
================================

Name: id_pipe_stage

Overview:
Parametrised MIPS decode stage that replaces the combinational ID block. It contains a 2-read/1-write register file with write-through bypass and immediate extension per opcode. It also performs destination-register selection and load-use hazard detection. Output goes to EX through a valid/ready pipeline register that supports stall, back-pressure and flush.

Parameters:
XLEN, 32, datapath and register width
NREG, 32, number of architectural registers; register 0 reads as zero
RAW, 5, register address width, equal to clog2(NREG)
RA_IDX, 31, link register index written by JAL/JALR

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  synchronous active-low reset
in_valid  in  1  IF presents an instruction
in_ins  in  32  instruction word
in_pc4  in  XLEN  PC+4 of the instruction, passed through
in_ready  out  1  ID accepts in_ins this cycle
wb_en  in  1  write-back enable
wb_addr  in  RAW  write-back register
wb_data  in  XLEN  write-back data
ex_is_load  in  1  instruction currently in EX is LW
ex_dst  in  RAW  destination register of the EX instruction
flush  in  1  branch/jump redirect; kill ID contents
out_valid  out  1  decoded bundle valid
out_ready  in  1  EX accepts the bundle
out_rdata1  out  XLEN  operand A
out_rdata2  out  XLEN  operand B
out_imm  out  XLEN  extended immediate
out_dst  out  RAW  destination register; 0 means no write
out_jadr  out  26  J/JAL target field
out_op  out  6  opcode, passed through
out_funct  out  6  funct field, passed through
out_pc4  out  XLEN  registered in_pc4

Behaviour:
- Reset (RST=0 at posedge):
  - All output registers go to 0 and out_valid goes to 0.
  - All NREG registers clear to 0.
  - in_ready is 0 during reset.
- Regfile:
  - Write at posedge when wb_en=1 and wb_addr!=0. Writes to r0 are ignored.
  - Reads are combinational.
  - If wb_en=1 and wb_addr equals a read address other than 0, the read returns wb_data (same-cycle bypass).
- Operands:
  - R-form default: rdata1=R[rs], rdata2=R[rt].
  - SLL/SRL/SRA: rdata1=R[rt], rdata2=zero-extended shamt.
  - SLLV/SRLV/SRAV: rdata1=R[rt], rdata2=R[rs].
  - MFHI/MFLO: both operands 0.
  - I-form: rdata1=R[rs]. rdata2=R[rt] for BEQ/BNE/SW; 0 otherwise.
  - J/JAL: both operands 0.
- Immediate (out_imm):
  - Sign-extended for ADDI, ADDIU, SLTI, SLTIU, LW, SW, BEQ, BNE, BLTZ, BGEZ, BLEZ, BGTZ.
  - Zero-extended for ANDI, ORI, XORI.
  - 0 for all other instructions.
- Destination (out_dst):
  - R-form: rd.
  - JALR: rd, or RA_IDX if rd=0.
  - ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LW: rt.
  - JAL: RA_IDX.
  - SW, branches, J, JR, MTHI/MTLO, MULT/DIV family: 0.
  - Unknown opcode: 0, but the bundle stays valid.
- Load-use hazard:
  - Asserted when ex_is_load=1, ex_dst!=0, and ex_dst equals an operand register the instruction actually uses.
  - While asserted, in_ready=0 and a bubble is inserted (out_valid goes to 0 on the next accept slot).
- Handshake:
  - Output register loads when out_ready=1 or out_valid=0.
  - in_ready = load_slot AND NOT hazard AND NOT flush.
  - A new instruction is accepted when in_valid=1 and in_ready=1.
  - out_valid next value = accepted.
  - With out_valid=1 and out_ready=0, every out_* field holds stable.
- Latency: 1 cycle from acceptance to out_valid.
- Captured operands are a snapshot. Values written back after capture are not re-read; EX forwarding covers that case.
- flush=1:
  - out_valid goes to 0 at the next posedge, regardless of out_ready.
  - in_ready=0 and the instruction on in_ins is dropped.
  - flush wins over hazard and over back-pressure.
  - The regfile write still occurs.
- Reset mid-stall or mid-flush: reset wins; the stage is empty afterwards.

Decomposition:
- Shared package mips_isa_pkg (header common_param.vh) holds:
  - opcode and funct localparams (R_FORM, ADDI, …, JALR);
  - REGFILE_SIZE;
  - a decode-bundle struct.
- Sub-module regfile_2r1w, parameters XLEN/NREG/RAW:
  - synchronous reset, r0 hardwired, write-through bypass;
  - reused later by a forwarding unit.

Test Plan:
- Bypass: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF, same cycle ADD r3,r5,r0 -> out_rdata1=0xDEADBEEF, out_dst=3, out_valid=1 one cycle later.
- Immediate: ADDI r2,r0,0xFFFC -> out_imm=0xFFFFFFFC. ORI r2,r0,0xFFFC -> out_imm=0x0000FFFC. Write to r0 with 0x1234 followed by a read of r0 -> 0.
- Load-use: ex_is_load=1, ex_dst=4, in_ins=ADD r1,r4,r2 -> in_ready=0 for 1 cycle and a bubble (out_valid=0). The next cycle with ex_is_load=0 accepts the instruction, giving out_valid=1.
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles with a new in_ins -> outputs unchanged and in_ready=0. out_ready=1 -> the new bundle appears the following cycle.
- Flush + stall: flush=1 together with a hazard and out_ready=0 -> out_valid=0 next cycle and the input is dropped. JAL 0x0000040 afterwards -> out_dst=31, out_jadr=0x0000040.
- Reset: RST=0 mid-stall with r7=0x55 -> all outputs 0, out_valid=0, r7 reads 0 after release.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: opcode/funct encodings, operand-select enums and
// the per-instruction decode-control bundle used by the ID stage.
package mips_isa_pkg;

  localparam int REGFILE_SIZE = 32;

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {A_RS, A_RT, A_ZERO} opa_sel_e;
  typedef enum logic [1:0] {B_RT, B_RS, B_SHAMT, B_ZERO} opb_sel_e;
  typedef enum logic [1:0] {IMM_ZERO, IMM_SEXT, IMM_ZEXT} imm_sel_e;
  typedef enum logic [2:0] {DST_NONE, DST_RD, DST_RT, DST_RA, DST_RD_OR_RA} dst_sel_e;

  typedef struct packed {
    opa_sel_e opa;
    opb_sel_e opb;
    imm_sel_e imm;
    dst_sel_e dst;
    logic     uses_rs;
    logic     uses_rt;
  } decode_ctrl_t;

  // Unknown opcodes fall through to the I-form default: read rs, no imm, no write.
  function automatic decode_ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
    decode_ctrl_t c;
    c = '{opa: A_RS, opb: B_ZERO, imm: IMM_ZERO, dst: DST_NONE, uses_rs: 1'b1, uses_rt: 1'b0};
    case (op)
      OP_R_FORM: begin
        c.opb     = B_RT;
        c.dst     = DST_RD;
        c.uses_rt = 1'b1;
        case (funct)
          F_SLL, F_SRL, F_SRA: begin
            c.opa     = A_RT;
            c.opb     = B_SHAMT;
            c.uses_rs = 1'b0;
          end
          F_SLLV, F_SRLV, F_SRAV: begin
            c.opa = A_RT;
            c.opb = B_RS;
          end
          F_MFHI, F_MFLO: begin
            c.opa     = A_ZERO;
            c.opb     = B_ZERO;
            c.uses_rs = 1'b0;
            c.uses_rt = 1'b0;
          end
          F_JR, F_MTHI, F_MTLO: begin
            c.dst     = DST_NONE;
            c.uses_rt = 1'b0;
          end
          F_JALR: begin
            c.dst     = DST_RD_OR_RA;
            c.uses_rt = 1'b0;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: c.dst = DST_NONE;
          default: ;
        endcase
      end
      OP_J, OP_JAL: begin
        c.opa     = A_ZERO;
        c.uses_rs = 1'b0;
        c.dst     = (op == OP_JAL) ? DST_RA : DST_NONE;
      end
      OP_BEQ, OP_BNE, OP_SW: begin
        c.opb     = B_RT;
        c.uses_rt = 1'b1;
        c.imm     = IMM_SEXT;
      end
      OP_REGIMM, OP_BLEZ, OP_BGTZ: c.imm = IMM_SEXT;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        c.imm = IMM_SEXT;
        c.dst = DST_RT;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        c.imm = IMM_ZEXT;
        c.dst = DST_RT;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with r0 hardwired to zero and same-cycle
// write-through bypass on both read ports.
module regfile_2r1w #(
  parameter int XLEN = 32,
  parameter int NREG = mips_isa_pkg::REGFILE_SIZE,
  parameter int RAW  = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            i_wen,
  input  logic [RAW-1:0]  i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [RAW-1:0]  i_raddr1,
  input  logic [RAW-1:0]  i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [NREG];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_wen && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Bypass lets an instruction read a value being written back this very cycle.
  function automatic logic [XLEN-1:0] read_port(input logic [RAW-1:0] addr);
    if (addr == '0)                   return '0;
    else if (i_wen && i_waddr == addr) return i_wdata;
    else                              return r_regs[addr];
  endfunction

  assign o_rdata1 = read_port(i_raddr1);
  assign o_rdata2 = read_port(i_raddr2);

endmodule

// File: rtl/id_pipe_stage.sv
// MIPS instruction-decode stage: regfile read with bypass, immediate and
// destination decode, load-use hazard detection and a valid/ready output register.
module id_pipe_stage #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int RAW    = 5,
  parameter int RA_IDX = 31
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  input  logic [31:0]     in_ins,
  input  logic [XLEN-1:0] in_pc4,
  output logic            in_ready,
  input  logic            wb_en,
  input  logic [RAW-1:0]  wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_is_load,
  input  logic [RAW-1:0]  ex_dst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata1,
  output logic [XLEN-1:0] out_rdata2,
  output logic [XLEN-1:0] out_imm,
  output logic [RAW-1:0]  out_dst,
  output logic [25:0]     out_jadr,
  output logic [5:0]      out_op,
  output logic [5:0]      out_funct,
  output logic [XLEN-1:0] out_pc4
);

  import mips_isa_pkg::*;

  logic [5:0]      w_op, w_funct;
  logic [RAW-1:0]  w_rs, w_rt, w_rd;
  logic [XLEN-1:0] w_rs_val, w_rt_val;
  logic [XLEN-1:0] w_opa, w_opb, w_imm;
  logic [RAW-1:0]  w_dst;
  decode_ctrl_t    w_ctrl;
  logic            w_hazard, w_load_slot, w_accept;

  logic            r_valid;
  logic [XLEN-1:0] r_rdata1, r_rdata2, r_imm, r_pc4;
  logic [RAW-1:0]  r_dst;
  logic [25:0]     r_jadr;
  logic [5:0]      r_op, r_funct;

  assign w_op    = in_ins[31:26];
  assign w_funct = in_ins[5:0];
  assign w_rs    = RAW'(in_ins[25:21]);
  assign w_rt    = RAW'(in_ins[20:16]);
  assign w_rd    = RAW'(in_ins[15:11]);
  assign w_ctrl  = decode_ctrl(w_op, w_funct);

  regfile_2r1w #(.XLEN(XLEN), .NREG(NREG), .RAW(RAW)) u_regfile (
    .CLK      (CLK),
    .RST      (RST),
    .i_wen    (wb_en),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rs_val),
    .o_rdata2 (w_rt_val)
  );

  always_comb begin
    w_opa = '0;
    w_opb = '0;
    w_imm = '0;
    w_dst = '0;
    case (w_ctrl.opa)
      A_RS:    w_opa = w_rs_val;
      A_RT:    w_opa = w_rt_val;
      default: w_opa = '0;
    endcase
    case (w_ctrl.opb)
      B_RT:    w_opb = w_rt_val;
      B_RS:    w_opb = w_rs_val;
      B_SHAMT: w_opb = {{(XLEN-5){1'b0}}, in_ins[10:6]};
      default: w_opb = '0;
    endcase
    case (w_ctrl.imm)
      IMM_SEXT: w_imm = {{(XLEN-16){in_ins[15]}}, in_ins[15:0]};
      IMM_ZEXT: w_imm = {{(XLEN-16){1'b0}}, in_ins[15:0]};
      default:  w_imm = '0;
    endcase
    case (w_ctrl.dst)
      DST_RD:       w_dst = w_rd;
      DST_RT:       w_dst = w_rt;
      DST_RA:       w_dst = RAW'(RA_IDX);
      DST_RD_OR_RA: w_dst = (w_rd == '0) ? RAW'(RA_IDX) : w_rd;
      default:      w_dst = '0;
    endcase
  end

  // Only registers the instruction really consumes can stall it behind a load.
  assign w_hazard = ex_is_load && (ex_dst != '0) &&
                    ((w_ctrl.uses_rs && (ex_dst == w_rs)) ||
                     (w_ctrl.uses_rt && (ex_dst == w_rt)));

  assign w_load_slot = out_ready || !r_valid;
  assign in_ready    = RST && w_load_slot && !w_hazard && !flush;
  assign w_accept    = in_valid && in_ready;

  // Flush kills the stage even under back-pressure; an empty accept slot is a bubble.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_valid  <= 1'b0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_dst    <= '0;
      r_jadr   <= '0;
      r_op     <= '0;
      r_funct  <= '0;
      r_pc4    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load_slot) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_rdata1 <= w_opa;
        r_rdata2 <= w_opb;
        r_imm    <= w_imm;
        r_dst    <= w_dst;
        r_jadr   <= in_ins[25:0];
        r_op     <= w_op;
        r_funct  <= w_funct;
        r_pc4    <= in_pc4;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_rdata1 = r_rdata1;
  assign out_rdata2 = r_rdata2;
  assign out_imm    = r_imm;
  assign out_dst    = r_dst;
  assign out_jadr   = r_jadr;
  assign out_op     = r_op;
  assign out_funct  = r_funct;
  assign out_pc4    = r_pc4;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Self-checking bench for id_pipe_stage: directed scenarios plus a randomized run
// scored against an instruction-level decode model with its own register array.
module tb_id_pipe_stage;

  logic        CLK, RST;
  logic        in_valid, in_ready;
  logic [31:0] in_ins, in_pc4;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_is_load;
  logic [4:0]  ex_dst;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_rdata1, out_rdata2, out_imm, out_pc4;
  logic [4:0]  out_dst;
  logic [25:0] out_jadr;
  logic [5:0]  out_op, out_funct;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_rf [32];

  typedef struct packed {
    logic [31:0] a, b, imm;
    logic [4:0]  dst;
    logic [25:0] jadr;
    logic [5:0]  op, funct;
    logic [31:0] pc4;
    logic        usesRs, usesRt;
  } exp_t;

  wire [170:0] dutBundle = {out_rdata1, out_rdata2, out_imm, out_dst, out_jadr, out_op, out_funct, out_pc4};

  id_pipe_stage #(.XLEN(32), .NREG(32), .RAW(5), .RA_IDX(31)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ins(in_ins), .in_pc4(in_pc4),
    .in_ready(in_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_is_load(ex_is_load), .ex_dst(ex_dst), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
    .out_imm(out_imm), .out_dst(out_dst), .out_jadr(out_jadr), .out_op(out_op),
    .out_funct(out_funct), .out_pc4(out_pc4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rIns(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] iIns(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] rdModel(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (wb_en && wb_addr == addr) return wb_data;
    return model_rf[addr];
  endfunction

  // Reference decode derived from the instruction-set rules, operands sampled now.
  function automatic exp_t modelDecode(input logic [31:0] ins, input logic [31:0] pc4);
    exp_t e;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    e = '0;
    e.jadr = ins[25:0]; e.op = op; e.funct = fn; e.pc4 = pc4;
    if (op == 6'h00) begin
      if (fn inside {6'h00, 6'h02, 6'h03}) begin
        e.a = rdModel(rt); e.b = {27'd0, ins[10:6]}; e.usesRt = 1'b1;
      end else if (fn inside {6'h04, 6'h06, 6'h07}) begin
        e.a = rdModel(rt); e.b = rdModel(rs); e.usesRs = 1'b1; e.usesRt = 1'b1;
      end else if (!(fn inside {6'h10, 6'h12})) begin
        e.a = rdModel(rs); e.b = rdModel(rt); e.usesRs = 1'b1;
        e.usesRt = !(fn inside {6'h08, 6'h09, 6'h11, 6'h13});
      end
      if (fn inside {6'h08, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B}) e.dst = 5'd0;
      else if (fn == 6'h09) e.dst = (rd == 5'd0) ? 5'd31 : rd;
      else e.dst = rd;
    end else if (op == 6'h02 || op == 6'h03) begin
      e.dst = (op == 6'h03) ? 5'd31 : 5'd0;
    end else begin
      e.a = rdModel(rs); e.usesRs = 1'b1;
      if (op inside {6'h04, 6'h05, 6'h2B}) begin
        e.b = rdModel(rt); e.usesRt = 1'b1;
      end
      if (op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B})
        e.imm = {{16{ins[15]}}, ins[15:0]};
      else if (op inside {6'h0C, 6'h0D, 6'h0E})
        e.imm = {16'd0, ins[15:0]};
      if (op inside {[6'h08:6'h0E], 6'h23}) e.dst = rt;
    end
    return e;
  endfunction

  function automatic logic [170:0] packExp(input exp_t e);
    return {e.a, e.b, e.imm, e.dst, e.jadr, e.op, e.funct, e.pc4};
  endfunction

  task automatic step();
    @(posedge CLK);
    if (!RST) begin
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    end else if (wb_en && wb_addr != 5'd0) begin
      model_rf[wb_addr] = wb_data;
    end
    #1;
  endtask

  task automatic idleInputs();
    in_valid = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    ex_is_load = 0; ex_dst = 0; flush = 0; out_ready = 1;
  endtask

  task automatic test_reset();
    RST = 0; idleInputs();
    in_valid = 1; in_ins = rIns(1, 2, 3, 0, 'h20); in_pc4 = 32'h44;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (dutBundle !== '0) begin errors++; $display("FAIL reset_bundle: got %h expected 0", dutBundle); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    RST = 1; in_valid = 0;
    step();
  endtask

  task automatic test_bypass();
    in_ins = rIns(5, 0, 3, 0, 'h20); in_pc4 = 32'h104; in_valid = 1;
    wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bypass_in_ready: got %b expected 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_rdata1 !== 32'hDEADBEEF || out_dst !== 5'd3 || out_pc4 !== 32'h104) begin
      errors++; $display("FAIL bypass_out: got v=%b a=%h dst=%0d pc4=%h expected v=1 a=deadbeef dst=3 pc4=104", out_valid, out_rdata1, out_dst, out_pc4);
    end
    in_valid = 0; wb_en = 0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bypass_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_immediate();
    in_valid = 1; in_ins = iIns('h08, 0, 2, 'hFFFC);
    step();
    checks++; if (out_imm !== 32'hFFFFFFFC || out_dst !== 5'd2) begin errors++; $display("FAIL addi_imm: got imm=%h dst=%0d expected fffffffc 2", out_imm, out_dst); end
    in_ins = iIns('h0D, 0, 2, 'hFFFC);
    step();
    checks++; if (out_imm !== 32'h0000FFFC) begin errors++; $display("FAIL ori_imm: got %h expected 0000fffc", out_imm); end
    wb_en = 1; wb_addr = 0; wb_data = 32'h1234; in_ins = rIns(0, 0, 1, 0, 'h20);
    step();
    checks++; if (out_rdata1 !== 32'd0) begin errors++; $display("FAIL r0_bypass: got %h expected 0", out_rdata1); end
    wb_en = 0;
    step();
    checks++; if (out_rdata1 !== 32'd0 || out_rdata2 !== 32'd0) begin errors++; $display("FAIL r0_read: got %h %h expected 0 0", out_rdata1, out_rdata2); end
    in_valid = 0;
    step();
  endtask

  task automatic test_load_use();
    exp_t e;
    ex_is_load = 1; ex_dst = 4; in_ins = rIns(4, 2, 1, 0, 'h20); in_pc4 = 32'h120; in_valid = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL loaduse_stall: got %b expected 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL loaduse_bubble: got %b expected 0", out_valid); end
    ex_is_load = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL loaduse_release: got %b expected 1", in_ready); end
    e = modelDecode(in_ins, in_pc4);
    step();
    checks++; if (out_valid !== 1'b1 || dutBundle !== packExp(e)) begin errors++; $display("FAIL loaduse_accept: got v=%b %h expected v=1 %h", out_valid, dutBundle, packExp(e)); end
    in_valid = 0;
    step();
  endtask

  task automatic test_back_pressure();
    exp_t eA, eB;
    in_valid = 1; in_ins = iIns('h08, 5, 6, 'h0011); in_pc4 = 32'h200;
    eA = modelDecode(in_ins, in_pc4);
    step();
    checks++; if (out_valid !== 1'b1 || dutBundle !== packExp(eA)) begin errors++; $display("FAIL bp_first: got v=%b %h expected v=1 %h", out_valid, dutBundle, packExp(eA)); end
    out_ready = 0; in_ins = rIns(5, 5, 7, 0, 'h21); in_pc4 = 32'h204;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0 (cycle %0d)", in_ready, k); end
      step();
      checks++; if (out_valid !== 1'b1 || dutBundle !== packExp(eA)) begin errors++; $display("FAIL bp_hold: got v=%b %h expected v=1 %h", out_valid, dutBundle, packExp(eA)); end
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", in_ready); end
    eB = modelDecode(in_ins, in_pc4);
    step();
    checks++; if (out_valid !== 1'b1 || dutBundle !== packExp(eB)) begin errors++; $display("FAIL bp_next: got v=%b %h expected v=1 %h", out_valid, dutBundle, packExp(eB)); end
    in_valid = 0;
    step();
  endtask

  task automatic test_flush_stall();
    in_valid = 1; in_ins = iIns('h08, 1, 3, 7); in_pc4 = 32'h2F0;
    step();
    out_ready = 0; flush = 1; ex_is_load = 1; ex_dst = 2; in_ins = rIns(2, 3, 4, 0, 'h20);
    wb_en = 1; wb_addr = 9; wb_data = 32'hCAFEF00D;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b expected 0", out_valid); end
    flush = 0; ex_is_load = 0; wb_en = 0; out_ready = 1; in_valid = 0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b expected 0", out_valid); end
    in_valid = 1; in_ins = {6'h03, 26'h0000040}; in_pc4 = 32'h300;
    step();
    checks++; if (out_valid !== 1'b1 || out_dst !== 5'd31 || out_jadr !== 26'h40 || out_rdata1 !== 32'd0) begin
      errors++; $display("FAIL jal: got v=%b dst=%0d jadr=%h a=%h expected 1 31 0000040 0", out_valid, out_dst, out_jadr, out_rdata1);
    end
    in_ins = rIns(9, 0, 1, 0, 'h20);
    step();
    checks++; if (out_rdata1 !== 32'hCAFEF00D) begin errors++; $display("FAIL flush_wb_kept: got %h expected cafef00d", out_rdata1); end
    in_valid = 0;
    step();
  endtask

  task automatic test_reset_mid_stall();
    wb_en = 1; wb_addr = 7; wb_data = 32'h55; in_ins = rIns(7, 0, 1, 0, 'h20); in_valid = 1;
    step();
    wb_en = 0;
    checks++; if (out_rdata1 !== 32'h55) begin errors++; $display("FAIL r7_setup: got %h expected 55", out_rdata1); end
    out_ready = 0; ex_is_load = 1; ex_dst = 7;
    step();
    RST = 0;
    step();
    checks++; if (out_valid !== 1'b0 || dutBundle !== '0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid_stall: got v=%b rdy=%b %h expected 0 0 0", out_valid, in_ready, dutBundle);
    end
    RST = 1; ex_is_load = 0; out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_rdata1 !== 32'd0) begin errors++; $display("FAIL r7_cleared: got v=%b a=%h expected 1 0", out_valid, out_rdata1); end
    in_valid = 0;
    step();
  endtask

  task automatic test_random();
    logic [5:0] opList [0:17];
    logic [5:0] fnList [0:18];
    logic         expValid, slot, hz, expReady, acc;
    logic [170:0] expB;
    exp_t         e;
    logic [31:0]  ins;
    opList = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
               6'h07, 6'h08, 6'h0A, 6'h0C, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    fnList = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06,
               6'h07, 6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h1A};
    idleInputs();
    step();
    expValid = 1'b0;
    expB = '0;
    for (int n = 0; n < 400; n++) begin
      ins = {opList[$urandom_range(0, 17)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 6'd0};
      if (ins[31:26] == 6'h00) ins[5:0] = fnList[$urandom_range(0, 18)];
      else ins[5:0] = 6'($urandom_range(0, 63));
      in_ins = ins; in_pc4 = $urandom; in_valid = ($urandom_range(0, 3) != 0);
      wb_en = $urandom_range(0, 1); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      ex_is_load = ($urandom_range(0, 2) == 0); ex_dst = 5'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0); flush = ($urandom_range(0, 9) == 0);
      #1;
      e = modelDecode(in_ins, in_pc4);
      slot = out_ready || !expValid;
      hz = ex_is_load && ex_dst != 5'd0 &&
           ((e.usesRs && ex_dst == ins[25:21]) || (e.usesRt && ex_dst == ins[20:16]));
      expReady = slot && !hz && !flush;
      checks++; if (in_ready !== expReady) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b ins=%h", n, in_ready, expReady, ins); end
      acc = in_valid && expReady;
      if (flush) expValid = 1'b0;
      else if (slot) begin
        expValid = acc;
        if (acc) expB = packExp(e);
      end
      step();
      checks++; if (out_valid !== expValid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, out_valid, expValid); end
      if (expValid) begin
        checks++; if (dutBundle !== expB) begin errors++; $display("FAIL rnd_bundle[%0d]: got %h expected %h", n, dutBundle, expB); end
      end
    end
    idleInputs();
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    in_ins = 0; in_pc4 = 0;
    test_reset();
    test_bypass();
    test_immediate();
    test_load_use();
    test_back_pressure();
    test_flush_stall();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
